// File: rtl/i2c_arb_pkg.sv
// +----------------------------------------------------------------------+
// | Module      : i2c_arb_pkg                                            |
// | Description : Shared types and constants for the I2C arbiter: FSM    |
// |               state encoding, address/data widths, timeout default.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package i2c_arb_pkg;

  localparam int c_ADDR_W          = 7;
  localparam int c_DATA_W          = 8;
  localparam int c_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_arbiter_rr.sv
// +----------------------------------------------------------------------+
// | Module      : rr_arbiter                                             |
// | Description : Combinational round-robin picker. Searches req starting|
// |               at ptr, wrapping from NUM_REQ-1 back to 0, and returns |
// |               the winner as a one-hot grant and a binary index.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  int w_cand;

  // Walk offsets from farthest to nearest so the nearest active requester wins last.
  always_comb begin
    grant  = '0;
    idx    = '0;
    w_cand = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = int'(ptr) + k;
      if (w_cand >= NUM_REQ) begin
        w_cand = w_cand - NUM_REQ;
      end
      if (|(req & (NUM_REQ'(1) << w_cand))) begin
        grant = NUM_REQ'(1) << w_cand;
        idx   = IDX_W'(w_cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_arbiter.sv
// +----------------------------------------------------------------------+
// | Module      : i2c_arbiter                                            |
// | Description : Round-robin arbiter sharing one I2C master among       |
// |               NUM_REQ requesters. IDLE accepts, ISSUE pulses m_start,|
// |               WAIT holds for m_done, RESP returns status one cycle.  |
// |               Optional WAIT timeout: define I2C_ARBITER_TIMEOUT_EN.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = c_TIMEOUT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*c_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*c_DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_rw,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic                         rsp_nack,
  output logic                         rsp_timeout,
  output logic [c_DATA_W-1:0]          rsp_rdata,
  output logic                         m_start,
  output logic [c_ADDR_W-1:0]          m_addr,
  output logic [c_DATA_W-1:0]          m_data,
  output logic                         m_rw,
  output logic                         m_abort,
  input  logic                         m_busy,
  input  logic                         m_done,
  input  logic                         m_nack,
  input  logic [c_DATA_W-1:0]          m_rdata,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int c_IDX_W = $clog2(NUM_REQ);

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_ptr;
  logic [c_IDX_W-1:0]   r_grant;
  logic [c_ADDR_W-1:0]  r_addr;
  logic [c_DATA_W-1:0]  r_data;
  logic                 r_rw;
  logic                 r_nack;
  logic [c_DATA_W-1:0]  r_rdata;

  logic [NUM_REQ-1:0]   w_grant;
  logic [c_IDX_W-1:0]   w_idx;
  logic                 w_accept;
  logic                 w_resp;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx)
  );

  // Acceptance is gated by reset_n so req_ready is forced low during reset too.
  assign w_accept  = reset_n && (r_state == ST_IDLE) && !m_busy && (|req_valid);
  assign w_resp    = (r_state == ST_RESP);

  assign req_ready = w_accept ? w_grant : '0;
  assign m_start   = (r_state == ST_ISSUE);
  assign m_addr    = r_addr;
  assign m_data    = r_data;
  assign m_rw      = r_rw;
  assign grant_id  = r_grant;
  assign rsp_valid = w_resp ? (NUM_REQ'(1) << r_grant) : '0;
  assign rsp_nack  = w_resp & r_nack;
  assign rsp_rdata = w_resp ? r_rdata : '0;

`ifdef I2C_ARBITER_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_tmo;

  // WAIT-cycle counter; the last permitted WAIT cycle aborts unless m_done arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= (r_state == ST_WAIT) ? r_cnt + 1'b1 : '0;
      r_tmo <= m_abort;
    end
  end

  assign m_abort     = (r_state == ST_WAIT) && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1)) && !m_done;
  assign rsp_timeout = w_resp & r_tmo;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign m_abort          = 1'b0;
  assign rsp_timeout      = 1'b0;
`endif

  // Transaction FSM: latch the winner's command, run it, return status, advance pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rw    <= 1'b0;
      r_nack  <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr[int'(w_idx)*c_ADDR_W +: c_ADDR_W];
            r_data  <= req_data[int'(w_idx)*c_DATA_W +: c_DATA_W];
            r_rw    <= req_rw[w_idx];
            r_grant <= w_idx;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (m_done) begin
            r_nack  <= m_nack;
            r_rdata <= r_rw ? m_rdata : '0;
            r_state <= ST_RESP;
          end else if (m_abort) begin
            r_nack  <= 1'b1;
            r_rdata <= '0;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_ptr   <= (r_grant == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requester ports (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of WAIT cycles before an abort.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: per-requester transaction request.
REQ-006 SHALL have port req_addr, input, NUM_REQ*7 bits: packed 7-bit slave addresses, requester i in bits [7i+6:7i].
REQ-007 SHALL have port req_data, input, NUM_REQ*8 bits: packed write bytes, requester i in bits [8i+7:8i].
REQ-008 SHALL have port req_rw, input, NUM_REQ bits: 1 = read, 0 = write.
REQ-009 SHALL have port req_ready, output, NUM_REQ bits: one-hot acceptance strobe.
REQ-010 SHALL have port rsp_valid, output, NUM_REQ bits: one-hot completion strobe.
REQ-011 SHALL have ports rsp_nack (output, 1 bit), rsp_timeout (output, 1 bit) and rsp_rdata (output, 8 bits): the completion status and read byte.
REQ-012 SHALL have ports m_start (output, 1), m_addr (output, 7), m_data (output, 8), m_rw (output, 1) and m_abort (output, 1): the command to the I2C master.
REQ-013 SHALL have ports m_busy (input, 1), m_done (input, 1), m_nack (input, 1) and m_rdata (input, 8): status from the I2C master.
REQ-014 SHALL have port grant_id, output, $clog2(NUM_REQ) bits: index of the current owner.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT and RESP.
REQ-016 IDLE: when m_busy=0 and any req_valid is set, SHALL combinationally assert req_ready for the round-robin winner in the same cycle.
- That cycle SHALL latch addr, data, rw and grant_id.
- The FSM SHALL then go to ISSUE.
REQ-017 Round-robin search SHALL start at pointer rr_ptr and wrap from NUM_REQ-1 to 0.
REQ-018 ISSUE: SHALL pulse m_start for exactly one cycle, with m_addr, m_data and m_rw driven from the latched values, then go to WAIT.
- m_addr, m_data and m_rw SHALL stay stable until RESP completes.
REQ-019 WAIT: on m_done=1, SHALL capture m_nack and m_rdata and go to RESP; m_done SHALL be ignored in every other state.
REQ-020 RESP: SHALL assert rsp_valid[grant_id] for one cycle and set rr_ptr to grant_id+1 (mod NUM_REQ), then return to IDLE.
- rsp_nack, rsp_timeout and rsp_rdata SHALL be valid only in that cycle and SHALL be 0 otherwise.
REQ-021 Acceptance-to-m_start latency SHALL be 1 cycle; m_done-to-rsp_valid latency SHALL be 1 cycle; the minimum request-to-request turnaround SHALL be 4 cycles.
REQ-022 rsp_rdata SHALL be 0 for write transactions.
REQ-023 A requester dropping req_valid before acceptance SHALL be skipped without penalty; a request SHALL be accepted at most once per req_ready pulse.
REQ-024 No req_ready SHALL be asserted outside IDLE or while m_busy=1.

Reset
REQ-025 On reset_n=0, SHALL asynchronously force state=IDLE, rr_ptr=0, grant_id=0, and all outputs (req_ready, rsp_*, m_*) to 0.
REQ-026 Reset asserted mid-transaction SHALL produce no rsp_valid and no m_abort; the first grant after reset SHALL search from requester 0.

Configuration
REQ-027 With macro I2C_ARBITER_TIMEOUT_EN defined, a counter SHALL run in WAIT.
- When it reaches TIMEOUT_CYCLES without m_done, it SHALL pulse m_abort for one cycle and go to RESP with rsp_timeout=1, rsp_nack=1 and rsp_rdata=0.
- If m_done and expiry coincide, m_done SHALL win.
REQ-028 Without I2C_ARBITER_TIMEOUT_EN, no counter SHALL exist, m_abort SHALL be tied to 0, rsp_timeout SHALL be tied to 0, and WAIT SHALL last until m_done.

Structure
REQ-029 Package i2c_arb_pkg SHALL hold the state enum, the address and data width constants (7, 8) and the TIMEOUT_CYCLES default.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and ptr; outputs one-hot grant and index).

Verification
REQ-031 Single request: req_valid=4'b0001, addr=7'h50, data=8'hAA, rw=0.
- Required: req_ready[0] at cycle 0, m_start at cycle 1 with 0x50/0xAA.
- m_done at cycle 5 -> rsp_valid[0] at cycle 6 with nack=0.
REQ-032 Round robin: req_valid=4'b1111 held for 4 transactions -> grant order 0,1,2,3, then 0 again.
REQ-033 Read with NACK: rw=1, master returns m_nack=1 and m_rdata=8'h3C -> rsp_nack=1, rsp_rdata=8'h3C.
REQ-034 Busy master: m_busy=1 with req_valid=4'b0010 -> no req_ready until m_busy falls, then req_ready[1].
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=16): no m_done -> m_abort 16 cycles into WAIT, rsp_timeout=1; with m_done on the expiry cycle instead -> rsp_timeout=0.
REQ-036 Reset in WAIT: all outputs 0 immediately, no rsp_valid, and the next grant goes to requester 0.
